fetch_stage: RTL and testbench

- Instruction-fetch stage of the ARM pipelined processor.
- Owns the program counter (PC), drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register for decode.
- Handles branch and R15-write redirects, stall and flush from the hazard unit, a boot state and a halt state.
- Provides a retired-fetch counter for bring-up.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// captures the returned word into the IF/ID register, with redirect, stall, flush and halt handling.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000,
  parameter int          COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            PCF,
  input  logic [31:0]            InstrF,
  input  logic                   StallF,
  input  logic                   StallD,
  input  logic                   FlushD,
  input  logic                   BranchTakenE,
  input  logic [31:0]            BranchTargetE,
  input  logic                   PCSrcW,
  input  logic [31:0]            ResultW,
  input  logic                   halt_req,
  output logic [31:0]            InstrD,
  output logic [31:0]            PCPlus8D,
  output logic                   ValidD,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [31:0]            WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            pc_plus8_q, pc_plus8_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus8_d = pc_plus8_q;
    valid_d    = valid_q;
    count_d    = count_q;

    // Halt beats any redirect on the same edge, and the PC never moves outside RUN.
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (BranchTakenE) begin
          pc_d = BranchTargetE & WORD_MASK;
        end else if (PCSrcW) begin
          pc_d = ResultW & WORD_MASK;
        end else if (!StallF) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase

    if (FlushD) begin
      instr_d    = BUBBLE_INSTR;
      pc_plus8_d = 32'd0;
      valid_d    = 1'b0;
    end else if (!StallD) begin
      if (state_q == ST_RUN) begin
        instr_d    = InstrF;
        pc_plus8_d = pc_q + 32'd8;
        valid_d    = 1'b1;
        if (count_q != '1) begin
          count_d = count_q + COUNT_ONE;
        end
      end else begin
        instr_d    = BUBBLE_INSTR;
        pc_plus8_d = 32'd0;
        valid_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      instr_q    <= BUBBLE_INSTR;
      pc_plus8_q <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus8_q <= pc_plus8_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign PCF         = pc_q;
  assign InstrD      = instr_q;
  assign PCPlus8D    = pc_plus8_q;
  assign ValidD      = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural fetch model compared every cycle,
// directed scenarios pinned with literal values, and randomized control traffic.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        StallF, StallD, FlushD;
   logic        BranchTakenE;
   logic [31:0] BranchTargetE;
   logic        PCSrcW;
   logic [31:0] ResultW;
   logic        halt_req;
   logic [31:0] InstrD, PCPlus8D;
   logic        ValidD, halted;
   logic [31:0] fetch_count;

   logic [31:0] pcfSat, instrDSat, pcPlus8DSat;
   logic        validDSat, haltedSat;
   logic [2:0]  fetchCountSat;

   int checkCount = 0;
   int errorCount = 0;

   localparam int M_BOOT = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   // Behavioural model of the fetch stage, kept at the level of "what the decode stage sees".
   int          mPhase = M_BOOT;
   logic [31:0] mPc = 32'd0;
   logic [31:0] mInstr = 32'd0;
   logic [31:0] mPc8 = 32'd0;
   logic        mValid = 1'b0;
   longint      mDelivered = 0;

   fetch_stage dut (
      .clk(clk), .reset(reset), .PCF(PCF), .InstrF(InstrF),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
      .PCSrcW(PCSrcW), .ResultW(ResultW), .halt_req(halt_req),
      .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
      .halted(halted), .fetch_count(fetch_count)
   );

   // Narrow-counter copy so that saturation is reachable within a short run.
   fetch_stage #(.COUNT_WIDTH(3)) dutSat (
      .clk(clk), .reset(reset), .PCF(pcfSat), .InstrF(InstrF),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
      .PCSrcW(PCSrcW), .ResultW(ResultW), .halt_req(halt_req),
      .InstrD(instrDSat), .PCPlus8D(pcPlus8DSat), .ValidD(validDSat),
      .halted(haltedSat), .fetch_count(fetchCountSat)
   );

   function automatic logic [31:0] imemWord(input logic [31:0] addr);
      return 32'hE280_0000 + {2'b00, addr[31:2]};
   endfunction

   assign InstrF = imemWord(PCF);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model update: decode sees the word at the old PC; the PC then follows the redirect rules.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mPhase = M_BOOT;
         mPc = 32'd0;
         mInstr = 32'd0;
         mPc8 = 32'd0;
         mValid = 1'b0;
         mDelivered = 0;
      end else begin
         if (FlushD || (!StallD && mPhase != M_RUN)) begin
            mInstr = 32'd0;
            mPc8 = 32'd0;
            mValid = 1'b0;
         end else if (!StallD) begin
            mInstr = imemWord(mPc);
            mPc8 = mPc + 32'd8;
            mValid = 1'b1;
            mDelivered++;
         end
         if (mPhase == M_BOOT) begin
            mPhase = M_RUN;
         end else if (mPhase == M_RUN) begin
            if (halt_req) mPhase = M_HALT;
            else if (BranchTakenE) mPc = {BranchTargetE[31:2], 2'b00};
            else if (PCSrcW) mPc = {ResultW[31:2], 2'b00};
            else if (!StallF) mPc = mPc + 32'd4;
         end
      end
   end

   // Every cycle compare both instances against the model, mid-cycle.
   always @(negedge clk) begin
      logic [31:0] satExp;
      satExp = (mDelivered > 7) ? 32'd7 : mDelivered[31:0];
      checkOutput("PCF", PCF, mPc);
      checkOutput("InstrD", InstrD, mInstr);
      checkOutput("PCPlus8D", PCPlus8D, mPc8);
      checkOutput("ValidD", {31'd0, ValidD}, {31'd0, mValid});
      checkOutput("halted", {31'd0, halted}, {31'd0, (mPhase == M_HALT)});
      checkOutput("fetch_count", fetch_count, mDelivered[31:0]);
      checkOutput("fetch_count_sat", {29'd0, fetchCountSat}, satExp);
      checkOutput("PCF_sat", pcfSat, mPc);
   end

   task automatic applyStimulus(input logic bt, input logic [31:0] tgt, input logic psw,
                                input logic [31:0] res, input logic sf, input logic sd,
                                input logic fd, input logic hr);
      BranchTakenE = bt;
      BranchTargetE = tgt;
      PCSrcW = psw;
      ResultW = res;
      StallF = sf;
      StallD = sd;
      FlushD = fd;
      halt_req = hr;
      @(posedge clk);
      #1;
   endtask

   task automatic randomStimulus(input bit allowHalt);
      applyStimulus($urandom_range(0, 99) < 12, $urandom, $urandom_range(0, 99) < 12, $urandom,
                    $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 10, allowHalt && ($urandom_range(0, 99) == 0));
   endtask

   initial begin
      reset = 1'b1;
      StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; BranchTargetE = 0;
      PCSrcW = 0; ResultW = 0; halt_req = 0;
      #1 reset = 1'b0;
      #2;
      checkOutput("rst_PCF", PCF, 32'h0);
      checkOutput("rst_ValidD", {31'd0, ValidD}, 32'd0);
      checkOutput("rst_count", fetch_count, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Boot bubble, then sequential delivery with one-cycle latency.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("tp1_boot_valid", {31'd0, ValidD}, 32'd0);
      checkOutput("tp1_boot_pc", PCF, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("tp1_instr0", InstrD, 32'hE280_0000);
      checkOutput("tp1_pc8_0", PCPlus8D, 32'd8);
      checkOutput("tp1_model_instr0", mInstr, 32'hE280_0000);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("tp1_instr1", InstrD, 32'hE280_0001);
      checkOutput("tp1_pc8_1", PCPlus8D, 32'd12);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("tp1_instr2", InstrD, 32'hE280_0002);
      checkOutput("tp1_pc8_2", PCPlus8D, 32'd16);
      checkOutput("tp1_count", fetch_count, 32'd3);
      checkOutput("tp1_model_count", mDelivered[31:0], 32'd3);

      // Branch overrides StallF, target aligned; flush on the same edge.
      applyStimulus(1, 32'h43, 0, 0, 1, 0, 1, 0);
      checkOutput("tp2_pc", PCF, 32'h40);
      checkOutput("tp2_valid", {31'd0, ValidD}, 32'd0);
      checkOutput("tp2_count", fetch_count, 32'd3);

      applyStimulus(1, 32'h80, 1, 32'h20, 0, 0, 0, 0);
      checkOutput("tp3_pc", PCF, 32'h80);
      checkOutput("tp3_instr", InstrD, 32'hE280_0010);
      checkOutput("tp3_count", fetch_count, 32'd4);

      applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 0);
      checkOutput("tp4_pc", PCF, 32'h10);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
         checkOutput("tp4_hold_pc", PCF, 32'h10);
         checkOutput("tp4_hold_instr", InstrD, 32'hE280_0020);
         checkOutput("tp4_hold_count", fetch_count, 32'd5);
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
      checkOutput("tp4_flush_valid", {31'd0, ValidD}, 32'd0);
      checkOutput("tp4_flush_instr", InstrD, 32'h0);
      checkOutput("tp4_flush_pc", PCF, 32'h14);

      // PC wrap at the top of the address space.
      applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
      checkOutput("tp5_pc_top", PCF, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("tp5_pc_wrap", PCF, 32'h0);
      checkOutput("tp5_pc8_wrap", PCPlus8D, 32'h4);
      checkOutput("tp5_instr", InstrD, 32'h227F_FFFF);
      checkOutput("tp5_count", fetch_count, 32'd7);
      checkOutput("tp5_sat_count", {29'd0, fetchCountSat}, 32'd7);

      for (int i = 0; i < 300; i++) randomStimulus(1'b0);

      // Halt wins over a simultaneous branch and freezes the PC.
      applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
      checkOutput("tp6_pre_pc", PCF, 32'h200);
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1);
      checkOutput("tp6_halted", {31'd0, halted}, 32'd1);
      checkOutput("tp6_pc_frozen", PCF, 32'h200);
      checkOutput("tp6_last_valid", {31'd0, ValidD}, 32'd1);
      checkOutput("tp6_last_instr", InstrD, 32'hE280_0080);
      applyStimulus(1, 32'h400, 1, 32'h500, 0, 0, 0, 0);
      checkOutput("tp6_pc_ignore", PCF, 32'h200);
      checkOutput("tp6_bubble", {31'd0, ValidD}, 32'd0);
      for (int i = 0; i < 20; i++) randomStimulus(1'b0);
      checkOutput("tp6_still_halted", {31'd0, halted}, 32'd1);

      // Asynchronous reset between clock edges.
      #2 reset = 1'b0;
      #1;
      checkOutput("arst_PCF", PCF, 32'h0);
      checkOutput("arst_halted", {31'd0, halted}, 32'd0);
      checkOutput("arst_count", fetch_count, 32'd0);
      checkOutput("arst_InstrD", InstrD, 32'h0);
      checkOutput("arst_PCPlus8D", PCPlus8D, 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 300; i++) randomStimulus(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
